// File: rtl/frame_ram_pkg.sv
// Shared frame-buffer RAM geometry, arbiter grant states and the buffered write entry.
package frame_ram_pkg;

    localparam int RAM_WIDTH = 32;
    localparam int RAM_DEPTH = (480 * 360 * 24) / RAM_WIDTH;
    localparam int ADDR_BITS = $clog2(RAM_DEPTH);
    localparam logic [ADDR_BITS-1:0] MAX_ADDR = ADDR_BITS'(RAM_DEPTH - 1);

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_READ,
        GNT_WRITE
    } gnt_state_t;

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [RAM_WIDTH-1:0] data;
    } wr_entry_t;

    function automatic logic addr_oob(input logic [ADDR_BITS-1:0] a);
        return a > MAX_ADDR;
    endfunction

endpackage

// File: rtl/wr_fifo.sv
// Small synchronous FIFO buffering loader writes until the arbiter finds a free RAM cycle.
module wr_fifo
    import frame_ram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push_i,
    input  wr_entry_t din_i,
    input  logic      pop_i,
    output wr_entry_t dout_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    wr_entry_t     mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + (PW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (PW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy lives entirely in the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/frame_ram_arbiter.sv
// Shares the single-port frame RAM between the VGA read path (always wins) and the
// buffered serial loader writes, which drain in cycles the display leaves idle.
module frame_ram_arbiter
    import frame_ram_pkg::*;
#(
    parameter int WFIFO_DEPTH  = 4,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_req,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic                 rd_valid,
    output logic [RAM_WIDTH-1:0] rd_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [RAM_WIDTH-1:0] wr_data,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic                 ram_we,
    output logic [RAM_WIDTH-1:0] ram_din,
    input  logic [RAM_WIDTH-1:0] ram_dout,
    output logic                 frame_done,
    output logic                 addr_err,
    output logic                 wr_starved
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    gnt_state_t           gnt_q, gnt_d;
    logic [ADDR_BITS-1:0] last_addr_q, last_addr_d;
    logic                 rd_oob_q;
    logic                 rd_valid_q;
    logic [RAM_WIDTH-1:0] rd_data_q;
    logic                 frame_done_q, frame_done_d;
    logic [SW-1:0]        starve_cnt_q, starve_cnt_d;

    logic      fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic      rd_oob, wr_oob;
    wr_entry_t wr_in, head;

    assign wr_in     = '{addr: wr_addr, data: wr_data};
    assign wr_ready  = !fifo_full;
    assign fifo_push = wr_valid && !fifo_full;

    wr_fifo #(
        .DEPTH(WFIFO_DEPTH)
    ) u_wr_fifo (
        .clk_i  (clk),
        .rst_ni (rst),
        .push_i (fifo_push),
        .din_i  (wr_in),
        .pop_i  (fifo_pop),
        .dout_o (head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign rd_oob = addr_oob(rd_addr);
    assign wr_oob = addr_oob(head.addr);

    // Out-of-range accesses keep the RAM address parked on the last legal value.
    always_comb begin
        gnt_d       = GNT_IDLE;
        fifo_pop    = 1'b0;
        ram_we      = 1'b0;
        ram_din     = '0;
        ram_addr    = last_addr_q;
        addr_err    = 1'b0;
        if (rd_req) begin
            gnt_d    = GNT_READ;
            addr_err = rd_oob;
            if (!rd_oob) ram_addr = rd_addr;
        end else if (!fifo_empty) begin
            gnt_d    = GNT_WRITE;
            fifo_pop = 1'b1;
            addr_err = wr_oob;
            if (!wr_oob) begin
                ram_we   = 1'b1;
                ram_din  = head.data;
                ram_addr = head.addr;
            end
        end
        addr_err     = addr_err && rst;
        last_addr_d  = ram_addr;
        frame_done_d = ram_we && (head.addr == MAX_ADDR);
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (ram_we)
            starve_cnt_d = '0;
        else if (!fifo_empty && rd_req && (starve_cnt_q != STARVE_MAX))
            starve_cnt_d = starve_cnt_q + SW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q        <= GNT_IDLE;
            last_addr_q  <= '0;
            rd_oob_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            frame_done_q <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            gnt_q        <= gnt_d;
            last_addr_q  <= last_addr_d;
            rd_oob_q     <= rd_oob;
            // ram_dout carries the word granted last cycle; capture it one edge later.
            rd_valid_q   <= (gnt_q == GNT_READ);
            rd_data_q    <= (gnt_q == GNT_READ && !rd_oob_q) ? ram_dout : '0;
            frame_done_q <= frame_done_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign frame_done = frame_done_q;
    assign wr_starved = (starve_cnt_q == STARVE_MAX);

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Scoreboard bench for frame_ram_arbiter: directed stimulus queues expected reads and
// RAM commits; a negedge monitor pops and compares whenever rd_valid or ram_we fires.
module tb_frame_ram_arbiter;

    localparam int STARVE_LIMIT = 1024;

    typedef struct packed {
        logic [16:0] addr;
        logic [31:0] data;
    } exp_wr_t;

    logic        clk;
    logic        rst;
    logic        rd_req;
    logic [16:0] rd_addr;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [16:0] wr_addr;
    logic [31:0] wr_data;
    logic [16:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic        frame_done;
    logic        addr_err;
    logic        wr_starved;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] rq[$];
    exp_wr_t     wq[$];
    logic [31:0] mem [0:131071];

    frame_ram_arbiter #(
        .WFIFO_DEPTH (4),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .frame_done(frame_done),
        .addr_err  (addr_err),
        .wr_starved(wr_starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM model, read-before-write.
    always @(posedge clk) begin
        ram_dout <= mem[ram_addr];
        if (ram_we) mem[ram_addr] = ram_din;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rd_valid) begin
            if (rq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_unexpected: got rd_valid with data %0h expected no read", rd_data);
            end else begin
                chk("rd_data", rd_data, rq.pop_front());
            end
        end
        if (ram_we) begin
            if (wq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wr_unexpected: got write addr %0d data %0h expected none", ram_addr, ram_din);
            end else begin
                exp_wr_t e;
                e = wq.pop_front();
                chk("wr_addr", ram_addr, e.addr);
                chk("wr_data", ram_din, e.data);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nwr;
        int nstale;
        for (int i = 0; i < 131072; i++) mem[i] = '0;
        mem[5]        = 32'hDEADBEEF;
        mem[10]       = 32'hCAFEF00D;
        mem[17'h1FFFF] = 32'hFFFFFFFF;
        rst = 1'b1; rd_req = 1'b0; rd_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        #1 rst = 1'b0;
        #2;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_starved", wr_starved, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_addr_err", addr_err, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // 1: single read, 2-cycle latency
        step();
        rd_req = 1'b1; rd_addr = 17'd5; rq.push_back(32'hDEADBEEF);
        step();
        rd_req = 1'b0;
        @(negedge clk) chk("t1_lat_n1", rd_valid, 0);
        @(negedge clk) chk("t1_valid_n2", rd_valid, 1);
        chk("t1_data_n2", rd_data, 32'hDEADBEEF);
        step();

        // 2: fill FIFO behind reads, then drain in order
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1; rd_addr = 17'd10; rq.push_back(32'hCAFEF00D);
            wr_valid = 1'b1; wr_addr = 17'(i); wr_data = 32'h11 * (i + 1);
            wq.push_back({17'(i), 32'h11 * (i + 1)});
            step();
        end
        rd_req = 1'b0; wr_valid = 1'b1; wr_addr = 17'd4; wr_data = 32'h55;
        @(negedge clk);
        chk("t2_full_ready", wr_ready, 0);
        chk("t2_first_commit", ram_we, 1);
        step();
        @(negedge clk);
        chk("t2_ready_after_pop", wr_ready, 1);
        wq.push_back({17'd4, 32'h55});
        step();
        wr_valid = 1'b0;
        repeat (5) step();

        // 3: starvation under continuous reads
        nwr = 0;
        rd_req = 1'b1; rd_addr = 17'd10;
        wr_valid = 1'b1; wr_addr = 17'd20; wr_data = 32'hA5A5A5A5;
        wq.push_back({17'd20, 32'hA5A5A5A5});
        for (int i = 0; i <= STARVE_LIMIT + 1; i++) begin
            rq.push_back(32'hCAFEF00D);
            @(negedge clk);
            if (ram_we) nwr++;
            if (i == STARVE_LIMIT) chk("t3_not_yet_starved", wr_starved, 0);
            if (i == STARVE_LIMIT + 1) chk("t3_starved", wr_starved, 1);
            step();
            wr_valid = 1'b0;
        end
        chk("t3_no_write_while_read", nwr, 0);
        rd_req = 1'b0;
        @(negedge clk);
        chk("t3_commit", ram_we, 1);
        chk("t3_starved_sticky", wr_starved, 1);
        step();
        @(negedge clk) chk("t3_starved_clear", wr_starved, 0);
        repeat (3) step();

        // 4: last-word write and out-of-range write
        wr_valid = 1'b1; wr_addr = 17'd129599; wr_data = 32'h12345678;
        wq.push_back({17'd129599, 32'h12345678});
        step();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("t4_commit", ram_we, 1);
        chk("t4_done_early", frame_done, 0);
        step();
        @(negedge clk) chk("t4_frame_done", frame_done, 1);
        step();
        @(negedge clk) chk("t4_done_pulse", frame_done, 0);
        step();
        wr_valid = 1'b1; wr_addr = 17'd129600; wr_data = 32'h99;
        step();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("t4_oob_we", ram_we, 0);
        chk("t4_oob_err", addr_err, 1);
        step();
        @(negedge clk);
        chk("t4_err_pulse", addr_err, 0);
        chk("t4_oob_no_done", frame_done, 0);

        // 5: out-of-range read returns zero
        step();
        rd_req = 1'b1; rd_addr = 17'h1FFFF; rq.push_back(32'h0);
        @(negedge clk);
        chk("t5_oob_err", addr_err, 1);
        chk("t5_oob_we", ram_we, 0);
        step();
        rd_req = 1'b0;
        repeat (4) step();
        chk("pre_t6_rq_drained", rq.size(), 0);
        chk("pre_t6_wq_drained", wq.size(), 0);

        // 6: reset with buffered writes and reads in flight
        for (int i = 0; i < 3; i++) begin
            rd_req = 1'b1; rd_addr = 17'd10; rq.push_back(32'hCAFEF00D);
            wr_valid = 1'b1; wr_addr = 17'(30 + i); wr_data = 32'h100 + i;
            wq.push_back({17'(30 + i), 32'h100 + i});
            step();
        end
        wr_valid = 1'b0;
        #1 rst = 1'b0;
        rq.delete();
        wq.delete();
        #1;
        chk("t6_rd_valid", rd_valid, 0);
        chk("t6_rd_data", rd_data, 0);
        chk("t6_wr_ready", wr_ready, 1);
        chk("t6_starved", wr_starved, 0);
        chk("t6_frame_done", frame_done, 0);
        chk("t6_addr_err", addr_err, 0);
        rd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        nstale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rd_valid || ram_we) nstale++;
        end
        chk("t6_no_stale", nstale, 0);
        step();
        chk("end_rq_empty", rq.size(), 0);
        chk("end_wq_empty", wq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
